deserializer: RTL

DESERIALIZER -- requirements
Module: deserializer

---
 rtl/deserializer_if.sv | 26 ++
 rtl/deserializer.sv | 90 +++++++++
 2 files changed

// File: rtl/deserializer_if.sv
// Serial-in / parallel-out bus for the deserializer: serial stream, sync pulse,
// output handshake and status flags.
interface deserializer_if #(
  parameter int WIDTH = 8
);
  logic             serial_in;
  logic             start;
  logic             out_ready;
  logic             err_clr;
  logic [WIDTH-1:0] data_out;
  logic             out_valid;
  logic             busy;
  logic             frame_err;
  logic             overrun;
  logic [7:0]       frame_cnt;

  modport slave (
    input  serial_in, start, out_ready, err_clr,
    output data_out, out_valid, busy, frame_err, overrun, frame_cnt
  );

  modport master (
    output serial_in, start, out_ready, err_clr,
    input  data_out, out_valid, busy, frame_err, overrun, frame_cnt
  );
endinterface

// File: rtl/deserializer.sv
// LSB-first serial-to-parallel converter framed by a one-cycle start pulse,
// with a valid/ready output register, sticky error flags and a frame counter.
module deserializer #(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  deserializer_if.slave  bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic {IDLE, RECV} state_t;

  state_t           state_reg;
  logic [CW-1:0]    cnt_reg;
  logic [WIDTH-1:0] shift_reg;
  logic [WIDTH-1:0] data_reg;
  logic             valid_reg;
  logic             frame_err_reg;
  logic             overrun_reg;
  logic [7:0]       frame_cnt_reg;
  logic [WIDTH-1:0] word_next;

  // The committed word must include the bit arriving on the final edge.
  always_comb begin
    word_next          = shift_reg;
    word_next[cnt_reg] = bus.serial_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      shift_reg     <= '0;
      data_reg      <= '0;
      valid_reg     <= 1'b0;
      frame_err_reg <= 1'b0;
      overrun_reg   <= 1'b0;
      frame_cnt_reg <= '0;
    end else begin
      // Clears come first so a set later in this block takes priority.
      if (bus.err_clr) begin
        frame_err_reg <= 1'b0;
        overrun_reg   <= 1'b0;
      end
      if (valid_reg && bus.out_ready) begin
        valid_reg <= 1'b0;
      end

      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            state_reg <= RECV;
            cnt_reg   <= '0;
            shift_reg <= '0;
          end
        end
        RECV: begin
          if (bus.start) begin
            frame_err_reg <= 1'b1;
            cnt_reg       <= '0;
            shift_reg     <= '0;
          end else if (cnt_reg == LAST_BIT) begin
            data_reg      <= word_next;
            valid_reg     <= 1'b1;
            frame_cnt_reg <= frame_cnt_reg + 8'd1;
            if (valid_reg && !bus.out_ready) begin
              overrun_reg <= 1'b1;
            end
            shift_reg <= word_next;
            cnt_reg   <= '0;
            state_reg <= IDLE;
          end else begin
            shift_reg <= word_next;
            cnt_reg   <= cnt_reg + 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.data_out  = data_reg;
  assign bus.out_valid = valid_reg;
  assign bus.busy      = (state_reg == RECV);
  assign bus.frame_err = frame_err_reg;
  assign bus.overrun   = overrun_reg;
  assign bus.frame_cnt = frame_cnt_reg;
endmodule
